motor_pos_error_ctl: RTL
========================

// Module: motor_pos_error_ctl
// PURPOSE
//  Parametrised position-error stage for the motor loop. Latches a target on a move
//  command (fixed 180 / fixed 90 / programmed setpoint) and computes the signed error,
//  magnitude and sign for every encoder sample through a 2-stage pipeline.
//  Tracks the move with an FSM: deadband check, settle qualification and timeout fault.
//  Feeds the PWM / direction logic downstream.
// PARAMETERS
//  POS_W        12    width of pos, setpoints and errorabs
//  SP_180       174   target for mode 2'b00
//  SP_90        87    target for mode 2'b01
//  DEADBAND     2     errorabs <= DEADBAND counts as in position
//  SETTLE_CNT   16    consecutive in-deadband samples required to settle (>=1)
//  TIMEOUT_CYC  2^20  clk_48 cycles allowed from command to settled (>=SETTLE_CNT+2)
// PORTS
//  clk_48     in   1        system clock; the only clock
//  reset      in   1        synchronous, active-high reset
//  mode       in   2        00=180, 01=90, 10=sp_prog, 11=reserved; sampled on command
//  sp_prog    in   POS_W    programmed setpoint; sampled on command
//  command    in   1        1-cycle move strobe
//  abort      in   1        1-cycle strobe; returns the FSM to IDLE
//  pos        in   POS_W    unsigned encoder position
//  pos_valid  in   1        pos is valid this cycle
//  error      out  POS_W+1  signed error = setpoint - pos
//  errorabs   out  POS_W    |error|
//  errorsign  out  1        1 = negative, 0 = zero or positive
//  err_valid  out  1        1-cycle pulse; error outputs updated this cycle
//  in_pos     out  1        errorabs <= DEADBAND for the latest sample
//  busy       out  1        FSM is in TRACK or SETTLE
//  settled    out  1        FSM is in DONE
//  timeout    out  1        FSM is in FAULT
// BEHAVIOUR
//  Reset: every output is 0; setpoint register = 0; FSM = IDLE; pipeline valids = 0.
//  Pipeline: cycle N pos_valid=1 -> stage-1 register captures pos -> cycle N+2 outputs
//   are updated and err_valid=1. Back-to-back pos_valid gives 1 result per cycle.
//   Outputs hold their values between err_valid pulses.
//  Arithmetic: error = {1'b0,setpoint} - {1'b0,pos} in POS_W+1 bits, so it never
//   overflows. errorabs = magnitude, which fits in POS_W bits.
//   errorsign = error[POS_W]. The error is computed in every FSM state.
//  Setpoint: loaded on an accepted command from mode (SP_180 / SP_90 / sp_prog).
//  FSM:
//   IDLE   : command and mode!=11 -> load setpoint, clear timers -> TRACK.
//   TRACK  : err_valid and in_pos -> SETTLE with settle_cnt=1
//            (if SETTLE_CNT=1 -> DONE directly).
//   SETTLE : err_valid and in_pos -> settle_cnt++; reaching SETTLE_CNT -> DONE.
//            err_valid and !in_pos -> settle_cnt=0 -> TRACK.
//            cycles without err_valid do not change settle_cnt.
//   DONE   : command and mode!=11 -> reload setpoint -> TRACK.
//            Leaving the deadband in DONE only drops in_pos; the state is unchanged.
//   FAULT  : only abort or reset leaves this state (-> IDLE).
//  Timeout: tmo_cnt counts every cycle in TRACK/SETTLE and clears on entry to TRACK
//   from IDLE or DONE. When tmo_cnt = TIMEOUT_CYC-1 and DONE is not reached in the
//   same cycle -> FAULT.
//  Retarget: command with mode!=11 in TRACK/SETTLE -> reload setpoint, clear
//   settle_cnt and tmo_cnt -> TRACK. Samples already in the pipeline use the new
//   setpoint from the cycle after the load.
//  Precedence: reset > abort > command > sample-driven transitions > timeout.
//  mode=11 with command: the command is ignored and the state is unchanged.
//  abort: from any state -> IDLE; error outputs and pipeline keep running.
//  in_pos is updated only on err_valid; it is 0 after reset.
// TESTING
//  1 reset -> all outputs 0. Then mode=00, command, pos=100 valid ->
//    2 cycles later error=74, errorabs=74, errorsign=0, err_valid=1, busy=1.
//  2 mode=01, pos=4095 (POS_W=12) -> error=-4008, errorabs=4008, errorsign=1;
//    no wrap at the bit-width boundaries.
//  3 mode=10, sp_prog=500, pos steps 490->499->500 held for 16 samples ->
//    in_pos=1 at 499; settled=1 exactly on the 16th in-deadband err_valid (DEADBAND=2).
//  4 in SETTLE at count 10, one sample pos=510 -> state TRACK, settle_cnt=0;
//    settling needs 16 new in-deadband samples.
//  5 TIMEOUT_CYC=64, pos never in band -> timeout=1 64 cycles after command;
//    command ignored in FAULT; abort -> IDLE, all status outputs 0.
//  6 command and abort in the same cycle -> IDLE. Command with mode=11 -> no change.
//    Retarget during SETTLE -> TRACK with the new setpoint and tmo_cnt cleared.

Source files
------------

// File: rtl/motor_pos_error_ctl_if.sv
// motor_pos_error_ctl_if: move command / encoder sample inputs and error / status outputs
interface motor_pos_error_ctl_if #(parameter int POS_W = 12);
    logic [1:0]       i_mode;
    logic [POS_W-1:0] i_sp_prog;
    logic             i_command;
    logic             i_abort;
    logic [POS_W-1:0] i_pos;
    logic             i_pos_valid;
    logic [POS_W:0]   o_error;
    logic [POS_W-1:0] o_errorabs;
    logic             o_errorsign;
    logic             o_err_valid;
    logic             o_in_pos;
    logic             o_busy;
    logic             o_settled;
    logic             o_timeout;
    modport master (
        output i_mode, i_sp_prog, i_command, i_abort, i_pos, i_pos_valid,
        input  o_error, o_errorabs, o_errorsign, o_err_valid, o_in_pos, o_busy, o_settled, o_timeout
    );
    modport slave (
        input  i_mode, i_sp_prog, i_command, i_abort, i_pos, i_pos_valid,
        output o_error, o_errorabs, o_errorsign, o_err_valid, o_in_pos, o_busy, o_settled, o_timeout
    );
endinterface

// File: rtl/motor_pos_error_ctl.sv
// motor_pos_error_ctl: 2-stage position-error pipeline with move tracking (deadband, settle, timeout)
module motor_pos_error_ctl #(
    parameter int POS_W       = 12,
    parameter int SP_180      = 174,
    parameter int SP_90       = 87,
    parameter int DEADBAND    = 2,
    parameter int SETTLE_CNT  = 16,
    parameter int TIMEOUT_CYC = 1 << 20
) (
    input logic                  clk_48,
    input logic                  reset,
    motor_pos_error_ctl_if.slave bus
);
    localparam int SC_W = $clog2(SETTLE_CNT + 1);
    localparam int TM_W = $clog2(TIMEOUT_CYC);
    typedef enum logic [2:0] {IDLE, TRACK, SETTLE, DONE, FAULT} state_t;
    state_t           r_state;
    logic [POS_W-1:0] r_sp, r_pos1;
    logic             r_v1;
    logic [SC_W-1:0]  r_scnt;
    logic [TM_W-1:0]  r_tmo;
    logic [POS_W:0]   w_err, w_neg;
    logic [POS_W-1:0] w_abs, w_sp_sel;
    logic             w_in_pos, w_cmd, w_hit, w_miss, w_done, w_tmo;
    assign w_err    = {1'b0, r_sp} - {1'b0, r_pos1};
    assign w_neg    = -w_err;
    assign w_abs    = w_err[POS_W] ? w_neg[POS_W-1:0] : w_err[POS_W-1:0];
    assign w_in_pos = w_abs <= POS_W'(DEADBAND);
    assign w_cmd    = bus.i_command && bus.i_mode != 2'b11;
    assign w_sp_sel = bus.i_mode == 2'b00 ? POS_W'(SP_180) :
                      bus.i_mode == 2'b01 ? POS_W'(SP_90) : bus.i_sp_prog;
    assign w_hit    = r_v1 && w_in_pos;
    assign w_miss   = r_v1 && !w_in_pos;
    // r_scnt is always 0 in TRACK, so one compare covers both TRACK and SETTLE
    assign w_done   = w_hit && r_scnt == SC_W'(SETTLE_CNT - 1);
    assign w_tmo    = r_tmo == TM_W'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk_48) begin
        if (reset) begin
            r_v1            <= 1'b0;
            r_pos1          <= '0;
            bus.o_err_valid <= 1'b0;
            bus.o_error     <= '0;
            bus.o_errorabs  <= '0;
            bus.o_errorsign <= 1'b0;
            bus.o_in_pos    <= 1'b0;
        end else begin
            r_v1            <= bus.i_pos_valid;
            r_pos1          <= bus.i_pos_valid ? bus.i_pos : r_pos1;
            bus.o_err_valid <= r_v1;
            if (r_v1) begin
                bus.o_error     <= w_err;
                bus.o_errorabs  <= w_abs;
                bus.o_errorsign <= w_err[POS_W];
                bus.o_in_pos    <= w_in_pos;
            end
        end
    end
    // sample decisions use the result being registered this edge, so status lines up with err_valid
    always_ff @(posedge clk_48) begin
        if (reset || bus.i_abort) begin
            r_state       <= IDLE;
            r_scnt        <= '0;
            r_tmo         <= '0;
            bus.o_busy    <= 1'b0;
            bus.o_settled <= 1'b0;
            bus.o_timeout <= 1'b0;
            if (reset) r_sp <= '0;
        end else if (w_cmd && r_state != FAULT) begin
            r_sp          <= w_sp_sel;
            r_state       <= TRACK;
            r_scnt        <= '0;
            r_tmo         <= '0;
            bus.o_busy    <= 1'b1;
            bus.o_settled <= 1'b0;
        end else if (r_state == TRACK || r_state == SETTLE) begin
            if (w_done) begin
                r_state       <= DONE;
                r_scnt        <= '0;
                bus.o_busy    <= 1'b0;
                bus.o_settled <= 1'b1;
            end else if (w_tmo) begin
                r_state       <= FAULT;
                r_scnt        <= '0;
                bus.o_busy    <= 1'b0;
                bus.o_timeout <= 1'b1;
            end else begin
                r_tmo   <= r_tmo + 1'b1;
                r_state <= w_hit ? SETTLE : w_miss ? TRACK : r_state;
                r_scnt  <= w_hit ? r_scnt + 1'b1 : w_miss ? '0 : r_scnt;
            end
        end
    end
endmodule
